julia_iter_engine: RTL and testbench



---
 rtl/julia_pkg.sv | 28 ++
 rtl/julia_iter_engine_if.sv | 47 ++++
 rtl/julia_step.sv | 48 ++++
 rtl/julia_iter_engine.sv | 104 ++++++++++
 tb/tb_julia_iter_engine.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/julia_pkg.sv
// Shared types and fixed-point helpers for the Julia/Mandelbrot engine.
package julia_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  // |z|^2 threshold of 4.0 at the 2*frac scale of a raw product sum
  function automatic logic signed [63:0] esc_limit(input int frac);
    return 64'sd4 <<< (2 * frac);
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/julia_iter_engine_if.sv
// Pixel-in / result-out valid-ready bundle of the iteration engine.
interface julia_iter_engine_if #(
  parameter int WIDTH  = 20,
  parameter int ITER_W = 8,
  parameter int TAG_W  = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic signed [WIDTH-1:0] c_real;
  logic signed [WIDTH-1:0] c_imag;
  logic signed [WIDTH-1:0] z_real;
  logic signed [WIDTH-1:0] z_imag;
  logic [TAG_W-1:0]        tag_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [ITER_W-1:0]       out_iter;
  logic                    out_escaped;
  logic signed [WIDTH-1:0] out_z_real;
  logic signed [WIDTH-1:0] out_z_imag;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, mode,
    output c_real, c_imag,
    output z_real, z_imag,
    output tag_in, out_ready,
    input  in_ready, out_valid,
    input  out_iter, out_escaped,
    input  out_z_real, out_z_imag,
    input  out_tag
  );

  modport slave (
    input  in_valid, mode,
    input  c_real, c_imag,
    input  z_real, z_imag,
    input  tag_in, out_ready,
    output in_ready, out_valid,
    output out_iter, out_escaped,
    output out_z_real, out_z_imag,
    output out_tag
  );

endinterface

// File: rtl/julia_step.sv
// One combinational z <- z^2 + c step with saturation and escape test.
module julia_step
  import julia_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int FRACTIONAL = 10
) (
  input  logic signed [WIDTH-1:0] z_real,
  input  logic signed [WIDTH-1:0] z_imag,
  input  logic signed [WIDTH-1:0] c_real,
  input  logic signed [WIDTH-1:0] c_imag,
  output logic signed [WIDTH-1:0] z_next_real,
  output logic signed [WIDTH-1:0] z_next_imag,
  output logic signed [2*WIDTH:0] mag,
  output logic                    escape
);

  logic signed [63:0] zr, zi, cr, ci;
  logic signed [63:0] rr, ii, ri;
  logic signed [63:0] sq_r, sq_i, dbl;
  logic signed [63:0] sum_r, sum_i, mag_w;
  logic               unused_hi;

  always_comb begin
    zr    = 64'(z_real);
    zi    = 64'(z_imag);
    cr    = 64'(c_real);
    ci    = 64'(c_imag);
    rr    = zr * zr;
    ii    = zi * zi;
    ri    = zr * zi;
    mag_w = rr + ii;
    // >>> on the signed product floors toward -inf
    sq_r  = saturate(rr >>> FRACTIONAL, WIDTH);
    sq_i  = saturate(ii >>> FRACTIONAL, WIDTH);
    dbl   = saturate((ri <<< 1) >>> FRACTIONAL, WIDTH);
    sum_r = saturate(sq_r - sq_i + cr, WIDTH);
    sum_i = saturate(dbl + ci, WIDTH);
  end

  assign z_next_real = sum_r[WIDTH-1:0];
  assign z_next_imag = sum_i[WIDTH-1:0];
  assign mag         = mag_w[2*WIDTH:0];
  assign escape      = mag_w >= esc_limit(FRACTIONAL);

  assign unused_hi = ^{sum_r[63:WIDTH], sum_i[63:WIDTH]};

endmodule

// File: rtl/julia_iter_engine.sv
// Sequential Julia/Mandelbrot iterator: one z^2 + c step per clock,
// stops on escape or iteration cap and holds the result until taken.
module julia_iter_engine
  import julia_pkg::*;
#(
  parameter int WIDTH      = 20,
  parameter int FRACTIONAL = 10,
  parameter int ITER_W     = 8,
  parameter int MAX_ITER   = 255,
  parameter int TAG_W      = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  julia_iter_engine_if.slave  bus,
  output logic                busy
);

  state_t state, state_nx;

  logic signed [WIDTH-1:0] c_r, c_i;
  logic signed [WIDTH-1:0] z_r, z_i;
  logic signed [WIDTH-1:0] zn_r, zn_i;
  logic signed [2*WIDTH:0] unused_mag;
  logic [TAG_W-1:0]        tag;
  logic [ITER_W-1:0]       cnt;
  logic                    escape;
  logic                    at_cap;
  logic                    accept;

  julia_step #(
    .WIDTH      (WIDTH),
    .FRACTIONAL (FRACTIONAL)
  ) u_step (
    .z_real      (z_r),
    .z_imag      (z_i),
    .c_real      (c_r),
    .c_imag      (c_i),
    .z_next_real (zn_r),
    .z_next_imag (zn_i),
    .mag         (unused_mag),
    .escape      (escape)
  );

  assign at_cap        = cnt == ITER_W'(MAX_ITER);
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign busy          = state != IDLE;
  assign accept        = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid)      state_nx = ITER;
      ITER:    if (escape || at_cap)  state_nx = DONE;
      DONE:    if (bus.out_ready)     state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      c_r             <= '0;
      c_i             <= '0;
      z_r             <= '0;
      z_i             <= '0;
      tag             <= '0;
      cnt             <= '0;
      bus.out_iter    <= '0;
      bus.out_escaped <= 1'b0;
      bus.out_z_real  <= '0;
      bus.out_z_imag  <= '0;
      bus.out_tag     <= '0;
    end else begin
      if (accept) begin
        c_r <= bus.c_real;
        c_i <= bus.c_imag;
        z_r <= bus.mode ? '0 : bus.z_real;
        z_i <= bus.mode ? '0 : bus.z_imag;
        tag <= bus.tag_in;
        cnt <= '0;
      end
      if (state == ITER) begin
        // escape wins over the cap when both hold on the same count
        if (escape || at_cap) begin
          bus.out_iter    <= cnt;
          bus.out_escaped <= escape;
          bus.out_z_real  <= z_r;
          bus.out_z_imag  <= z_i;
          bus.out_tag     <= tag;
        end else begin
          z_r <= zn_r;
          z_i <= zn_i;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_julia_iter_engine.sv
// Randomised and directed bench for julia_iter_engine against
// a plain-integer reference of the escape-time iteration.
module tb_julia_iter_engine;

  localparam int W    = 20;
  localparam int F    = 10;
  localparam int IW   = 8;
  localparam int MAXI = 255;
  localparam int TW   = 16;

  localparam longint HI = (64'sd1 <<< (W - 1)) - 1;
  localparam longint LO = -(64'sd1 <<< (W - 1));

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic busy;

  julia_iter_engine_if #(
    .WIDTH(W), .ITER_W(IW), .TAG_W(TW)
  ) bus ();

  julia_iter_engine #(
    .WIDTH(W), .FRACTIONAL(F), .ITER_W(IW),
    .MAX_ITER(MAXI), .TAG_W(TW)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          e_iter;
  bit          e_esc;
  longint      e_zr, e_zi;
  logic [TW-1:0] e_tag;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > HI) return HI;
    if (v < LO) return LO;
    return v;
  endfunction

  task automatic model(
    input  bit     m,
    input  longint cr, ci, zr0, zi0,
    output int     it,
    output bit     esc,
    output longint ozr, ozi
  );
    longint zr, zi, nr, ni;
    zr  = m ? 0 : zr0;
    zi  = m ? 0 : zi0;
    it  = 0;
    esc = 0;
    for (int k = 0; k <= MAXI; k++) begin
      it = k;
      if (zr * zr + zi * zi >= (longint'(4) << (2 * F))) begin
        esc = 1;
        break;
      end
      if (k == MAXI) break;
      nr = sat(sat((zr * zr) >>> F)
             - sat((zi * zi) >>> F) + cr);
      ni = sat(sat((2 * zr * zi) >>> F) + ci);
      zr = nr;
      zi = ni;
    end
    ozr = zr;
    ozi = zi;
  endtask

  task automatic set_pixel(
    input bit            m,
    input longint        cr, ci, zr, zi,
    input logic [TW-1:0] t
  );
    model(m, cr, ci, zr, zi, e_iter, e_esc, e_zr, e_zi);
    e_tag      = t;
    bus.mode   = m;
    bus.c_real = W'(cr);
    bus.c_imag = W'(ci);
    bus.z_real = W'(zr);
    bus.z_imag = W'(zi);
    bus.tag_in = t;
  endtask

  task automatic accept_pixel();
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.mode     = 1'($urandom);
    bus.c_real   = W'($urandom);
    bus.c_imag   = W'($urandom);
    bus.z_real   = W'($urandom);
    bus.z_imag   = W'($urandom);
    bus.tag_in   = TW'($urandom);
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    for (int i = 1; i <= MAXI + 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check("out_valid_seen", lat != 0, 1);
    if (lat != 0) begin
      check("latency", lat, e_iter + 2);
      check("out_iter", bus.out_iter, e_iter);
      check("out_escaped", bus.out_escaped, e_esc);
      check("out_z_real", bus.out_z_real, e_zr);
      check("out_z_imag", bus.out_z_imag, e_zi);
      check("out_tag", bus.out_tag, e_tag);
      check("done_in_ready", bus.in_ready, 0);
      check("done_busy", busy, 1);
    end
  endtask

  task automatic finish_handshake();
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_pixel(
    input bit            m,
    input longint        cr, ci, zr, zi,
    input logic [TW-1:0] t
  );
    set_pixel(m, cr, ci, zr, zi, t);
    accept_pixel();
    wait_result();
    finish_handshake();
  endtask

  function automatic longint rnd_val(input bit wide);
    logic signed [W-1:0] t;
    t = W'($urandom);
    if (wide) return longint'(t);
    return longint'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    int            h_iter;
    longint        h_zr;
    logic [TW-1:0] h_tag;
    int            vcount;
    bit            wide;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = 1'b0;
    bus.c_real    = '0;
    bus.c_imag    = '0;
    bus.z_real    = '0;
    bus.z_imag    = '0;
    bus.tag_in    = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_iter", bus.out_iter, 0);
    check("rst_out_escaped", bus.out_escaped, 0);
    check("rst_out_z_real", bus.out_z_real, 0);
    check("rst_out_z_imag", bus.out_z_imag, 0);
    check("rst_out_tag", bus.out_tag, 0);
    n_rst = 1'b1;
    @(negedge clk);

    run_pixel(0, 0, 0, 0, 0, 16'h1111);
    run_pixel(0, 0, 0, 'h800, 0, 16'h2222);
    run_pixel(1, 'h400, 0, 'h123, 'h456, 16'hBEEF);
    run_pixel(0, 'h7FC00, 0, 'h400, 0, 16'h3333);
    run_pixel(0, -'h80000, 0, 0, 'h400, 16'h4444);

    bus.out_ready = 1'b0;
    set_pixel(1, 'h400, 0, 0, 0, 16'h0B0B);
    accept_pixel();
    wait_result();
    h_iter = e_iter;
    h_zr   = e_zr;
    h_tag  = e_tag;
    set_pixel(0, 0, 0, 'h800, 0, 16'h0C0C);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_iter", bus.out_iter, h_iter);
      check("bp_out_z_real", bus.out_z_real, h_zr);
      check("bp_out_tag", bus.out_tag, h_tag);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rel_out_valid", bus.out_valid, 0);
    check("bp_rel_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    check("bp_next_in_ready", bus.in_ready, 0);
    wait_result();
    finish_handshake();

    set_pixel(0, 0, 0, 0, 0, 16'h5A5A);
    accept_pixel();
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_iter", bus.out_iter, 0);
    check("mid_rst_escaped", bus.out_escaped, 0);
    check("mid_rst_z_real", bus.out_z_real, 0);
    check("mid_rst_z_imag", bus.out_z_imag, 0);
    check("mid_rst_tag", bus.out_tag, 0);
    @(negedge clk);
    n_rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check("mid_rst_no_valid", vcount, 0);
    check("mid_rst_idle", busy, 0);
    run_pixel(1, 'h100, 'h200, 0, 0, 16'h6666);

    for (int n = 0; n < 40; n++) begin
      wide = $urandom_range(0, 4) == 0;
      run_pixel(1'($urandom), rnd_val(wide), rnd_val(wide),
                rnd_val(wide), rnd_val(wide), TW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
